// File: rtl/jtframe_romrq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : jtframe_romrq                                              |
// | Description : Game-side ROM request cache in front of an SDRAM           |
// |               controller. Fetches 32-bit words and serves DW-wide        |
// |               slices, with a small tag cache and one fetch in flight.    |
// | Config      : JTFRAME_ROMRQ_CACHE_EN -> 2-entry round-robin cache,       |
// |               otherwise a single entry.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module jtframe_romrq #(
  parameter int AW = 18,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [21:0]   offset,
  input  logic [AW-1:0] addr,
  input  logic          addr_ok,
  output logic [DW-1:0] dout,
  output logic          data_ok,
  output logic          sdram_req,
  output logic [21:0]   sdram_addr,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [31:0]   data_read
);

  // Number of DW-wide units per 32-bit word is 2**SH
  localparam int SH = (DW == 8) ? 2 : ((DW == 16) ? 1 : 0);
  localparam int TW = AW - SH;

`ifdef JTFRAME_ROMRQ_CACHE_EN
  localparam int NE = 2;
`else
  localparam int NE = 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [TW-1:0]   w_tag;
  logic [TW:0]     w_word;
  logic [21:0]     w_fetch;

  logic [NE-1:0]   r_valid;
  logic [TW-1:0]   r_tag  [NE];
  logic [31:0]     r_data [NE];
  logic [NE-1:0]   w_sel;

  logic            w_hit;
  logic [31:0]     w_hword;
  logic            w_start;
  logic            w_fill;
  logic [DW-1:0]   w_sub_hit;
  logic [DW-1:0]   w_sub_rd;

  logic            r_req;
  logic [21:0]     r_saddr;
  logic [TW-1:0]   r_ftag;
  logic            r_drop;
  logic            r_ok;
  logic [DW-1:0]   r_dout;

  // Word address of the 32-bit word holding addr; wraps inside the 22-bit space
  assign w_tag   = addr[AW-1:SH];
  assign w_word  = {w_tag, 1'b0};
  assign w_fetch = offset + 22'(w_word);

  // Tag lookup across all cache entries
  always_comb begin
    w_hit   = 1'b0;
    w_hword = '0;
    for (int i = 0; i < NE; i++) begin
      if (r_valid[i] && (r_tag[i] == w_tag)) begin
        w_hit   = 1'b1;
        w_hword = r_data[i];
      end
    end
  end

  // Little-endian slice of the hit word and of the word arriving from SDRAM
  generate
    if (DW == 8) begin : g_dw8
      assign w_sub_hit = w_hword[{addr[1:0], 3'b000} +: 8];
      assign w_sub_rd  = data_read[{addr[1:0], 3'b000} +: 8];
    end else if (DW == 16) begin : g_dw16
      assign w_sub_hit = w_hword[{addr[0], 4'b0000} +: 16];
      assign w_sub_rd  = data_read[{addr[0], 4'b0000} +: 16];
    end else begin : g_dw32
      assign w_sub_hit = w_hword;
      assign w_sub_rd  = data_read;
    end
  endgenerate

`ifdef JTFRAME_ROMRQ_CACHE_EN
  logic r_ptr;

  // Round-robin victim pointer, advanced on every fill
  always_ff @(posedge clk) begin
    if (!rst_n)      r_ptr <= 1'b0;
    else if (w_fill) r_ptr <= ~r_ptr;
  end

  assign w_sel = {r_ptr, ~r_ptr};
`else
  assign w_sel = 1'b1;
`endif

  // Cache storage: clr wipes the valid bits and beats a simultaneous fill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (clr) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < NE; i++) begin
        if (w_fill && w_sel[i]) begin
          r_valid[i] <= 1'b1;
          r_tag[i]   <= r_ftag;
          r_data[i]  <= data_read;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; a fetch always runs to data_rdy, clr only suppresses the fill
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_fill      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (addr_ok && !w_hit) begin
          w_state_nxt = S_REQ;
          w_start     = 1'b1;
        end
      end
      S_REQ: begin
        if (sdram_ack) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (data_rdy) begin
          w_state_nxt = S_IDLE;
          w_fill      = !clr && !r_drop;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // SDRAM request handshake and bookkeeping of the tag being fetched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req   <= 1'b0;
      r_saddr <= '0;
      r_ftag  <= '0;
      r_drop  <= 1'b0;
    end else if (w_start) begin
      r_req   <= 1'b1;
      r_saddr <= w_fetch;
      r_ftag  <= w_tag;
      r_drop  <= 1'b0;
    end else begin
      if ((r_state == S_REQ) && sdram_ack) r_req <= 1'b0;
      if ((r_state != S_IDLE) && clr)      r_drop <= 1'b1;
    end
  end

  // Registered data path: forward the filling word, else serve cache hits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ok   <= 1'b0;
      r_dout <= '0;
    end else if (clr) begin
      r_ok   <= 1'b0;
    end else if (w_fill && addr_ok && (w_tag == r_ftag)) begin
      r_ok   <= 1'b1;
      r_dout <= w_sub_rd;
    end else if (addr_ok && w_hit) begin
      r_ok   <= 1'b1;
      r_dout <= w_sub_hit;
    end else begin
      r_ok   <= 1'b0;
    end
  end

  assign sdram_req  = r_req;
  assign sdram_addr = r_saddr;
  assign data_ok    = r_ok;
  assign dout       = r_dout;

endmodule
`default_nettype wire

// File: doc/jtframe_romrq.md
JTFRAME_ROMRQ -- requirements
Module: jtframe_romrq

Interface
REQ-001 Parameter AW, default 18: game-side ROM address width in DW-wide units.
REQ-002 Parameter DW, default 8: output data width; legal values 8, 16, 32.
REQ-003 clk  in  1  system clock; one clock domain; reset is synchronous and active-low.
REQ-004 rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 clr  in  1  cache invalidate, e.g. at the end of a ROM download.
REQ-006 offset  in  22  base of this ROM region in SDRAM, in 16-bit word units.
REQ-007 addr  in  AW  game ROM address.
REQ-008 addr_ok  in  1  addr is valid this cycle.
REQ-009 dout  out  DW  data for addr.
REQ-010 data_ok  out  1  dout corresponds to the current addr.
REQ-011 sdram_req  out  1  fetch request to the SDRAM controller.
REQ-012 sdram_addr  out  22  fetch address, in 16-bit word units.
REQ-013 sdram_ack  in  1  controller accepted the request.
REQ-014 data_rdy  in  1  data_read is valid this cycle.
REQ-015 data_read  in  32  fetched 32-bit word; lower address is in [15:0].

Function
REQ-016 SH SHALL be log2(32/DW); tag = addr[AW-1:SH]; the fetch address SHALL be offset + {tag,1'b0}, computed mod 2^22.
REQ-017 The sub-word select SHALL be little-endian: DW=8 selects data_read[8*addr[1:0]+:8]; DW=16 selects data_read[16*addr[0]+:16].
REQ-018 The cache SHALL hold 2 entries of {valid, tag, 32-bit word}; replacement SHALL be round-robin via a 1-bit pointer that toggles on every fill.
REQ-019 The FSM SHALL have states IDLE, REQ and WAIT.
REQ-020 IDLE -> REQ when addr_ok=1 and the lookup misses; sdram_req rises on the cycle following the miss, and sdram_addr is registered at the same time.
REQ-021 REQ: sdram_req and sdram_addr SHALL stay stable until sdram_ack=1; sdram_req drops the cycle after the ack; next state WAIT.
REQ-022 WAIT: on data_rdy=1, write data_read into the entry at the pointer, set valid, toggle the pointer, and return to IDLE.
REQ-023 A hit SHALL give dout and data_ok=1 registered one cycle after the cycle where addr_ok=1 and the tag matches a valid entry.
REQ-024 A miss SHALL give data_ok=1 one cycle after the fill, provided addr still matches the filled tag.
REQ-025 data_ok SHALL be 0 in any cycle following a cycle with addr_ok=0 or a tag mismatch; it SHALL never be high for a stale address.
REQ-026 If addr changes during REQ or WAIT, the fetch SHALL complete and fill; the new addr is then evaluated from IDLE with no aborted SDRAM transaction.
REQ-027 data_rdy or sdram_ack received in IDLE SHALL be ignored.
REQ-028 clr=1 SHALL clear all valid bits next cycle and force data_ok=0.
REQ-029 If clr=1 occurs in REQ, the request SHALL still complete through WAIT.
REQ-030 If clr=1 occurs in REQ or WAIT, the returned word SHALL be discarded (no fill, no data_ok) and the FSM returns to IDLE.
REQ-031 If clr=1 coincides with data_rdy, clr SHALL win.
REQ-032 While the FSM is not in IDLE, a hit on the other entry SHALL still be served per REQ-023.

Reset
REQ-033 While rst_n=0 at a clock edge: state IDLE; sdram_req=0; sdram_addr=0; dout=0; data_ok=0; all valid bits 0; pointer 0.
REQ-034 Reset asserted during REQ or WAIT SHALL abort the transaction, and sdram_req SHALL be 0 from the following cycle.
REQ-035 After an abort by reset, a late data_rdy SHALL be ignored per REQ-027.

Configuration
REQ-036 Macro JTFRAME_ROMRQ_CACHE_EN selects the cache depth.
REQ-037 With JTFRAME_ROMRQ_CACHE_EN defined, the cache SHALL be the 2-entry round-robin cache of REQ-018.
REQ-038 Without JTFRAME_ROMRQ_CACHE_EN, the cache SHALL have one entry, the pointer logic SHALL be absent, and each fill overwrites that entry; all other timing is unchanged.

Verification
REQ-039 DW=8, offset=0x1000, addr=0x0005 with addr_ok=1 -> sdram_req rises next cycle with sdram_addr=0x1002.
REQ-040 Continuing REQ-039: ack, then data_rdy with data_read=0xDDCCBBAA -> data_ok=1 the cycle after data_rdy, dout=0xBB.
REQ-041 addr=0x0006 after REQ-040 -> no sdram_req; data_ok=1 one cycle later with dout=0xCC.
REQ-042 Misses on tags 1, 2, 3 in sequence with cache enabled -> the entry for tag 1 is evicted, and a re-read of tag 3 hits; with the macro undefined, a re-read of tag 2 misses.
REQ-043 addr changes from 0x0005 to 0x0100 during WAIT -> the fill completes, data_ok stays 0, and a second request goes out at offset+0x80.
REQ-044 rst_n=0 during WAIT, then a late data_rdy -> sdram_req=0, data_ok=0, and no fill occurs; the same case with clr=1 coinciding with data_rdy -> no fill and data_ok stays 0.
